// File: rtl/divmod_seq_if.sv
// Go/ready handshake bundle for divmod_seq: operands and sign mode in, quotient/remainder/error out.
interface divmod_seq_if #(
    parameter int unsigned WIDTH_LOG = 4
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    logic             go;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             error;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] mod;

    modport master (output go, sign, a, b, input ready, error, div, mod);
    modport slave  (input go, sign, a, b, output ready, error, div, mod);
endinterface

// File: rtl/divmod_seq.sv
// Sequential shift-subtract divider with PREP/FIXUP sign handling and defined divide-by-zero.
// Define DIVMOD_SEQ_SIGNED_EN to honour the sign input; otherwise every operation is unsigned.
module divmod_seq #(
    parameter int unsigned WIDTH_LOG = 4
) (
    input  logic        clk,
    input  logic        rst,
    divmod_seq_if.slave bus
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;
    localparam int unsigned HI    = WIDTH - 1;

    typedef enum logic [2:0] {
        ST_READY,
        ST_ERROR,
        ST_PREP,
        ST_SUBTRACT,
        ST_FIXUP
    } state_e;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 sgn_q, sgn_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH_LOG-1:0] k_q, k_d;
    logic                 nq_q, nq_d;
    logic                 nr_q, nr_d;

    logic                 sign_c;
    logic [WIDTH-1:0]     ua_c, ub_c, sub_c;
    logic [WIDTH-1:0]     div_res_c, mod_res_c;
    logic [WIDTH_LOG-1:0] s_c;

    function automatic logic [WIDTH_LOG-1:0] msb_idx(input logic [WIDTH-1:0] x);
        msb_idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (x[i]) msb_idx = WIDTH_LOG'(i);
        end
    endfunction

`ifdef DIVMOD_SEQ_SIGNED_EN
    assign sign_c    = bus.sign;
    assign ua_c      = (sgn_q && opa_q[HI]) ? -opa_q : opa_q;
    assign ub_c      = (sgn_q && opb_q[HI]) ? -opb_q : opb_q;
    assign div_res_c = nq_q ? -quo_q : quo_q;
    assign mod_res_c = nr_q ? -rem_q : rem_q;
`else
    logic [2:0] unused_sign_bits;
    assign unused_sign_bits = {bus.sign, nq_q, nr_q};
    assign sign_c    = 1'b0;
    assign ua_c      = opa_q;
    assign ub_c      = opb_q;
    assign div_res_c = quo_q;
    assign mod_res_c = rem_q;
`endif

    // Only meaningful when ua >= ub, which guarantees msb(ua) >= msb(ub).
    assign s_c   = msb_idx(ua_c) - msb_idx(ub_c);
    assign sub_c = opb_q << k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            div_q   <= '0;
            mod_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            k_q     <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            error_q <= error_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            k_q     <= k_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        error_d = error_q;
        div_d   = div_q;
        mod_d   = mod_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        k_d     = k_q;
        nq_d    = nq_q;
        nr_d    = nr_q;

        unique case (state_q)
            ST_READY, ST_ERROR: begin
                if (bus.go) begin
                    if (bus.b == '0) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        div_d   = '1;
                        mod_d   = bus.a;
                    end else begin
                        state_d = ST_PREP;
                        ready_d = 1'b0;
                        error_d = 1'b0;
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        sgn_d   = sign_c;
                    end
                end
            end
            // Raw operands still in opa/opb here; opb is replaced by |b| for the subtract loop.
            ST_PREP: begin
                opb_d   = ub_c;
                rem_d   = ua_c;
                quo_d   = '0;
                k_d     = s_c;
                nq_d    = sgn_q & (opa_q[HI] ^ opb_q[HI]);
                nr_d    = sgn_q & opa_q[HI];
                state_d = (ua_c < ub_c) ? ST_FIXUP : ST_SUBTRACT;
            end
            ST_SUBTRACT: begin
                if (rem_q >= sub_c) begin
                    rem_d      = rem_q - sub_c;
                    quo_d[k_q] = 1'b1;
                end
                if (k_q == '0) begin
                    state_d = ST_FIXUP;
                end else begin
                    k_d = k_q - WIDTH_LOG'(1);
                end
            end
            ST_FIXUP: begin
                div_d   = div_res_c;
                mod_d   = mod_res_c;
                ready_d = 1'b1;
                state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    assign bus.ready = ready_q;
    assign bus.error = error_q;
    assign bus.div   = div_q;
    assign bus.mod   = mod_q;
endmodule

// File: tb/tb_divmod_seq.sv
// Directed scoreboard bench for divmod_seq (WIDTH_LOG=4); signed expectations follow DIVMOD_SEQ_SIGNED_EN.
module tb_divmod_seq;
    localparam int unsigned WIDTH_LOG = 4;

`ifdef DIVMOD_SEQ_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [15:0] div;
        logic [15:0] mod;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divmod_seq_if #(.WIDTH_LOG(WIDTH_LOG)) bus ();
    divmod_seq #(.WIDTH_LOG(WIDTH_LOG)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb[$];
    exp_t dropped;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t_go        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 32-bit integer division (truncating, remainder follows dividend).
    function automatic exp_t model(input string tag, input logic [15:0] a, input logic [15:0] b,
                                   input logic sg);
        exp_t e;
        int   sa, db, ua, ub;
        logic s;
        s     = sg & SGN_EN;
        e.tag = tag;
        if (b == 16'd0) begin
            e.div = 16'hFFFF;
            e.mod = a;
            e.err = 1'b1;
            e.lat = 0;
            return e;
        end
        sa    = s ? int'($signed(a)) : int'(a);
        db    = s ? int'($signed(b)) : int'(b);
        ua    = (sa < 0) ? -sa : sa;
        ub    = (db < 0) ? -db : db;
        e.div = 16'(sa / db);
        e.mod = 16'(sa % db);
        e.err = 1'b0;
        e.lat = (ua < ub) ? 2 : ($clog2(ua + 1) - $clog2(ub + 1)) + 3;
        return e;
    endfunction

    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sg);
        @(negedge clk);
        bus.go   = 1'b1;
        bus.a    = a;
        bus.b    = b;
        bus.sign = sg;
        sb.push_back(model(tag, a, b, sg));
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        t_go   = cyc;
    endtask

    task automatic wait_result();
        exp_t e;
        int   budget;
        budget = 0;
        while (bus.ready !== 1'b1 && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        e = sb.pop_front();
        chk({e.tag, " ready"}, 32'(bus.ready), 32'd1);
        chk({e.tag, " latency"}, 32'(cyc - t_go), 32'(e.lat));
        chk({e.tag, " div"}, 32'(bus.div), 32'(e.div));
        chk({e.tag, " mod"}, 32'(bus.mod), 32'(e.mod));
        chk({e.tag, " error"}, 32'(bus.error), 32'(e.err));
    endtask

    initial begin
        rst      = 1'b1;
        bus.go   = 1'b0;
        bus.sign = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(bus.ready), 32'd1);
        chk("reset error", 32'(bus.error), 32'd0);
        chk("reset div", 32'(bus.div), 32'd0);
        chk("reset mod", 32'(bus.mod), 32'd0);
        rst = 1'b0;

        start_op("u100_7", 16'd100, 16'd7, 1'b0);          wait_result();
        start_op("u5_9", 16'd5, 16'd9, 1'b0);              wait_result();
        start_op("u0_3", 16'd0, 16'd3, 1'b0);              wait_result();
        start_op("divzero", 16'h1234, 16'h0000, 1'b0);     wait_result();
        start_op("clear_err", 16'd1000, 16'd10, 1'b0);     wait_result();
        start_op("s_m7_2", 16'hFFF9, 16'h0002, 1'b1);      wait_result();
        start_op("s_7_m2", 16'h0007, 16'hFFFE, 1'b1);      wait_result();
        start_op("s_min_m1", 16'h8000, 16'hFFFF, 1'b1);    wait_result();

        // Second go while busy must be ignored and must not re-sample operands.
        start_op("repulse", 16'hFFFF, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.go = 1'b1;
        bus.a  = 16'd1;
        bus.b  = 16'd1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        wait_result();

        // Reset mid-operation aborts and restores reset values.
        start_op("abort", 16'hFFFF, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dropped = sb.pop_front();
        chk("abort ready", 32'(bus.ready), 32'd1);
        chk("abort error", 32'(bus.error), 32'd0);
        chk("abort div", 32'(bus.div), 32'd0);
        chk("abort mod", 32'(bus.mod), 32'd0);

        start_op("post_rst", 16'd200, 16'd3, 1'b0);        wait_result();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
